// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, state type and helpers for the LFSR encrypt stage
package lfsr_pkg;
    localparam logic [5:0] LFSR_TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
    localparam logic [7:0] PREAMBLE_CHAR = 8'h5F;
    typedef enum logic [2:0] {IDLE, LOAD, PRE, MSG, DONE} enc_state_t;
    // Out-of-range selects map to an empty tap set so the table is never over-indexed
    function automatic logic [5:0] taps_of(input logic [2:0] sel);
        return (sel > 3'd5) ? 6'h00 : LFSR_TAPS[sel];
    endfunction
    // A run is accepted only with a legal tap index and a nonzero seed
    function automatic logic cfg_ok(input logic [2:0] sel, input logic [5:0] sd);
        return (sel <= 3'd5) && (sd != 6'd0);
    endfunction
endpackage

// File: rtl/lfsr6b.sv
// lfsr6b: 6-bit Fibonacci LFSR with synchronous load and step enable
module lfsr6b (
    input  logic       clk,
    input  logic       init_n,
    input  logic       en,
    input  logic       init,
    input  logic [5:0] seed,
    input  logic [5:0] taps,
    output logic [5:0] q
);
    // Load takes priority over stepping; the feedback bit enters at the LSB
    always_ff @(posedge clk or negedge init_n)
        if (!init_n)
            q <= '0;
        else if (init)
            q <= seed;
        else if (en)
            q <= {q[4:0], ^(q & taps)};
endmodule

// File: rtl/lfsr_encrypt_stage.sv
// lfsr_encrypt_stage: writes a preamble plus LFSR-scrambled plaintext image into data memory
module lfsr_encrypt_stage
    import lfsr_pkg::*;
#(
    parameter int PRE_LEN  = 7,
    parameter int MSG_LEN  = 64,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 64
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    input  logic [2:0] tap_sel,
    input  logic [5:0] seed,
    output logic [7:0] mem_raddr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       err
);
    if (DST_BASE + MSG_LEN - 1 > 255) begin : g_range_check
        $error("encrypted image does not fit in the 8-bit address space");
    end

    enc_state_t state, state_nx;
    logic [7:0] cnt;
    logic [2:0] tap_q;
    logic [5:0] seed_q;
    logic [5:0] s;
    logic       wr;

    // State register
    always_ff @(posedge clk or negedge init_n)
        if (!init_n)
            state <= IDLE;
        else
            state <= state_nx;

    // Run configuration and rejection flag, captured only when a start is accepted
    always_ff @(posedge clk or negedge init_n)
        if (!init_n) begin
            tap_q  <= '0;
            seed_q <= '0;
            err    <= 1'b0;
        end else if (state == IDLE && start) begin
            tap_q  <= tap_sel;
            seed_q <= seed;
            err    <= !cfg_ok(tap_sel, seed);
        end

    // Byte counter spans preamble and message so it doubles as the write offset
    always_ff @(posedge clk or negedge init_n)
        if (!init_n)
            cnt <= '0;
        else
            cnt <= (state == LOAD) ? 8'd0 : wr ? cnt + 8'd1 : cnt;

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !start ? IDLE : cfg_ok(tap_sel, seed) ? LOAD : DONE;
            LOAD:    state_nx = PRE;
            PRE:     state_nx = (cnt == 8'(PRE_LEN - 1)) ? MSG : PRE;
            MSG:     state_nx = (cnt == 8'(MSG_LEN - 1)) ? DONE : MSG;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs; the read address runs one byte ahead so mem_rdata lines up with each MSG write
    always_comb begin
        wr        = (state == PRE) || (state == MSG);
        busy      = wr || (state == LOAD);
        done      = (state == DONE);
        mem_wr_en = wr;
        mem_waddr = wr ? 8'(DST_BASE) + cnt : 8'h00;
        mem_raddr = (state == MSG || (state == PRE && cnt == 8'(PRE_LEN - 1)))
                    ? 8'(SRC_BASE) + cnt + 8'd1 - 8'(PRE_LEN) : 8'h00;
        mem_wdata = (state == PRE) ? PREAMBLE_CHAR ^ {2'b00, s}
                  : (state == MSG) ? mem_rdata ^ {2'b00, s} : 8'h00;
    end

    lfsr6b u_lfsr (
        .clk    (clk),
        .init_n (init_n),
        .en     (wr),
        .init   (state == LOAD),
        .seed   (seed_q),
        .taps   (taps_of(tap_q)),
        .q      (s)
    );
endmodule

// File: tb/tb_lfsr_encrypt_stage.sv
// tb_lfsr_encrypt_stage: directed self-checking bench for the LFSR encrypt stage
module tb_lfsr_encrypt_stage;
    logic       clk = 1'b0;
    logic       init_n, start;
    logic [2:0] tap_sel;
    logic [5:0] seed;
    logic [7:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic       mem_wr_en, busy, done, err;
    logic [7:0] mem [256];
    logic [5:0] tb_taps [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
    logic [7:0] last_waddr;
    int         checks = 0, failures = 0;
    int         wr_cnt, gap_err, hi_err, done_cnt, busy_seen;
    int         cyc, ndone;
    int         done_at [3];

    always #5 clk = ~clk;

    lfsr_encrypt_stage dut (
        .clk       (clk),
        .init_n    (init_n),
        .start     (start),
        .tap_sel   (tap_sel),
        .seed      (seed),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Memory read port: data valid the cycle after the address
    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    // Memory write port plus write-stream scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (mem_waddr > 8'd127 || (mem_waddr != 8'd64 && mem_waddr != last_waddr + 8'd1)) gap_err++;
            if (mem_waddr >= 8'd71 && mem_wdata[7:6] != mem[mem_waddr - 8'd71][7:6]) hi_err++;
            mem[mem_waddr] = mem_wdata;
            last_waddr = mem_waddr;
            wr_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; gap_err = 0; hi_err = 0; done_cnt = 0; busy_seen = 0;
    endtask

    task automatic clear_dst();
        for (int k = 64; k < 128; k++) mem[k] = 8'h00;
    endtask

    // Leaves the bench at the negedge of cycle 1 (first cycle after the sampling edge)
    task automatic do_start(input logic [2:0] t, input logic [5:0] sd);
        @(negedge clk);
        clear_mon();
        tap_sel = t; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (done !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
    endtask

    // Reference image: preamble/plaintext XOR the LFSR state, stepping once per byte
    task automatic check_image(input string tag, input int t, input logic [5:0] sd);
        logic [5:0] s;
        logic [7:0] e;
        s = sd;
        for (int k = 0; k < 64; k++) begin
            e = ((k < 7) ? 8'h5F : mem[k - 7]) ^ {2'b00, s};
            chk($sformatf("%s[%0d]", tag, 64 + k), mem[64 + k], e);
            s = {s[4:0], ^(s & tb_taps[t])};
        end
    endtask

    initial begin
        string msg;
        init_n = 1'b0; start = 1'b0; tap_sel = '0; seed = '0;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_waddr", mem_waddr, 8'h00);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_raddr", mem_raddr, 8'h00);
        @(negedge clk);
        init_n = 1'b1;

        // Seed 01, taps 21, plaintext with both top bits exercised
        for (int j = 0; j < 57; j++) mem[j] = 8'(j * 29 + 8'h91);
        clear_dst();
        do_start(3'd0, 6'h01);
        chk("t1_busy_c1", busy, 1'b1);
        chk("t1_err_c1", err, 1'b0);
        wait_done(cyc);
        chk("t1_done_cycle", cyc, 66);
        chk("t1_err", err, 1'b0);
        chk("t1_wr_cnt", wr_cnt, 64);
        chk("t1_gaps", gap_err, 0);
        chk("t1_hi_bits", hi_err, 0);
        chk("t1_mem64", mem[64], 8'h5E);
        chk("t1_mem65", mem[65], 8'h5C);
        chk("t1_mem66", mem[66], 8'h58);
        check_image("t1_img", 0, 6'h01);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_busy_idle", busy, 1'b0);

        // Text round trip with seed 2A, taps 33
        msg = "Mr. Watson, come here. I want to see you.";
        for (int j = 0; j < 57; j++) mem[j] = (j < msg.len()) ? msg[j] : 8'h20;
        clear_dst();
        do_start(3'd3, 6'h2A);
        wait_done(cyc);
        chk("t2_done_cycle", cyc, 66);
        chk("t2_wr_cnt", wr_cnt, 64);
        chk("t2_gaps", gap_err, 0);
        check_image("t2_img", 3, 6'h2A);

        // Rejected runs: illegal tap index, then zero seed
        do_start(3'd6, 6'h01);
        chk("t3a_done", done, 1'b1);
        chk("t3a_err", err, 1'b1);
        chk("t3a_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        chk("t3a_done_low", done, 1'b0);
        chk("t3a_err_held", err, 1'b1);
        chk("t3a_writes", wr_cnt, 0);
        chk("t3a_busy_seen", busy_seen, 0);
        do_start(3'd1, 6'h00);
        chk("t3b_done", done, 1'b1);
        chk("t3b_err", err, 1'b1);
        repeat (2) @(negedge clk);
        chk("t3b_writes", wr_cnt, 0);
        chk("t3b_busy_seen", busy_seen, 0);
        chk("t3b_done_cnt", done_cnt, 1);

        // Asynchronous reset at cycle 20, then a clean rerun
        for (int j = 0; j < 57; j++) mem[j] = 8'(8'hE3 - j * 11);
        clear_dst();
        do_start(3'd5, 6'h3F);
        chk("t4_err_cleared", err, 1'b0);
        repeat (19) @(negedge clk);
        chk("t4_busy_pre_rst", busy, 1'b1);
        #1 init_n = 1'b0;
        #1;
        chk("t4_wr_en_rst", mem_wr_en, 1'b0);
        chk("t4_busy_rst", busy, 1'b0);
        chk("t4_done_rst", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_partial_writes", wr_cnt, 19);
        init_n = 1'b1;
        clear_dst();
        do_start(3'd5, 6'h3F);
        wait_done(cyc);
        chk("t4_done_cycle", cyc, 66);
        chk("t4_wr_cnt", wr_cnt, 64);
        check_image("t4_img", 5, 6'h3F);

        // Start held for 200 cycles: runs repeat with one IDLE cycle between DONE and LOAD
        clear_dst();
        @(negedge clk);
        clear_mon();
        tap_sel = 3'd2; seed = 6'h15; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done === 1'b1 && ndone < 3) begin
                done_at[ndone] = i;
                ndone++;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_done_cnt", done_cnt, 3);
        chk("t5_ndone", ndone, 3);
        chk("t5_done0", done_at[0], 66);
        chk("t5_done1", done_at[1], 133);
        chk("t5_done2", done_at[2], 200);
        chk("t5_wr_cnt", wr_cnt, 192);
        chk("t5_gaps", gap_err, 0);
        chk("t5_hi_bits", hi_err, 0);
        chk("t5_busy_after", busy, 1'b0);
        check_image("t5_img", 2, 6'h15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
